// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the JTAG initiator.
package jtag_master_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StScan,
    StResp
  } state_e;

  localparam int unsigned TLR_PULSES  = 5;
  localparam int unsigned DR_OVERHEAD = 5;
  localparam int unsigned IR_OVERHEAD = 6;

  // TMS for pulse idx of a scan starting in Run-Test/Idle. The header walks to Shift
  // (1,0,0 or 1,1,0,0); with len=0 its last pulse goes Capture->Exit1 instead.
  function automatic logic scan_tms(input logic ir, input int unsigned len,
                                    input int unsigned idx);
    int unsigned hdr;
    hdr = ir ? IR_OVERHEAD - 2 : DR_OVERHEAD - 2;
    if (idx < hdr) begin
      if (idx == hdr - 1) return (len == 0);
      return (idx < hdr - 2);
    end
    if (idx < hdr + len) return (idx == hdr + len - 1);
    return (idx == hdr + len);
  endfunction

endpackage

// File: rtl/jtag_master_clk_gen.sv
// Divides tck into jtag_tck pulses: CLK_DIV cycles low then CLK_DIV cycles high.
module jtag_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic tck,
  input  logic trst,
  input  logic en,
  output logic jtag_tck,
  output logic rise,
  output logic pulse_end
);

  localparam int unsigned CW = $clog2(2 * CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_d;

  // rise: jtag_tck goes high at the end of this cycle; pulse_end: it goes low.
  always_comb begin
    rise      = en && (cnt_q == CW'(CLK_DIV - 1));
    pulse_end = en && (cnt_q == CW'(2 * CLK_DIV - 1));
    cnt_d     = (en && !pulse_end) ? cnt_q + 1'b1 : '0;
    tck_d     = en && (cnt_d >= CW'(CLK_DIV));
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      cnt_q    <= '0;
      jtag_tck <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      jtag_tck <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: runs IR/DR scans and TAP resets from a valid/ready command stream.
// Optional macro JTAG_MASTER_RTI_EN adds cmd_rti extra Run-Test/Idle pulses per scan.
module jtag_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic               cmd_tlr,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_MASTER_RTI_EN
  input  logic [7:0]         cmd_rti,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

`ifdef JTAG_MASTER_RTI_EN
  localparam int unsigned RtiMax = 255;
`else
  localparam int unsigned RtiMax = 0;
`endif
  localparam int unsigned IW = $clog2(MAX_LEN + IR_OVERHEAD + RtiMax + 1);
  localparam int unsigned BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      last_q, last_d;
  logic               ir_q, ir_d;
  logic               tlr_q, tlr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic               clk_en, rise, pulse_end;
  logic [LEN_W-1:0]   len_clamp;
  int unsigned        hdr, len_u, cur, nxt, rti, n_pulses;
  logic               cur_shift, nxt_shift;

  assign clk_en = (state_q == StInit) || (state_q == StScan);

  jtag_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .tck      (tck),
    .trst     (trst),
    .en       (clk_en),
    .jtag_tck (jtag_tck),
    .rise     (rise),
    .pulse_end(pulse_end)
  );

  always_comb begin
    len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
`ifdef JTAG_MASTER_RTI_EN
    rti = 32'(cmd_rti);
`else
    rti = 0;
`endif
    n_pulses  = (cmd_ir ? IR_OVERHEAD : DR_OVERHEAD) + 32'(len_clamp) + rti;
    hdr       = ir_q ? IR_OVERHEAD - 2 : DR_OVERHEAD - 2;
    len_u     = 32'(len_q);
    cur       = 32'(idx_q);
    nxt       = cur + 1;
    cur_shift = (cur >= hdr) && (cur < hdr + len_u);
    nxt_shift = (nxt >= hdr) && (nxt < hdr + len_u);

    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ir_d    = ir_q;
    tlr_d   = tlr_q;
    len_d   = len_q;
    data_d  = data_q;
    rsp_d   = rsp_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;

    unique case (state_q)
      StInit: begin
        if (pulse_end) begin
          if (idx_q == last_q) begin
            state_d = tlr_q ? StResp : StIdle;
            idx_d   = '0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            tms_d = (nxt < TLR_PULSES);
          end
        end
      end
      StIdle: begin
        if (cmd_valid) begin
          idx_d = '0;
          tms_d = 1'b1;
          tdi_d = 1'b0;
          rsp_d = '0;
          tlr_d = cmd_tlr;
          if (cmd_tlr) begin
            state_d = StInit;
            last_d  = IW'(TLR_PULSES);
          end else begin
            state_d = StScan;
            ir_d    = cmd_ir;
            len_d   = len_clamp;
            data_d  = cmd_data;
            last_d  = IW'(n_pulses - 1);
          end
        end
      end
      StScan: begin
        if (rise && cur_shift) rsp_d[BW'(cur - hdr)] = jtag_tdo;
        if (pulse_end) begin
          if (idx_q == last_q) begin
            state_d = StResp;
            idx_d   = '0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
            tms_d = scan_tms(ir_q, len_u, nxt);
            tdi_d = nxt_shift ? data_q[BW'(nxt - hdr)] : 1'b0;
          end
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q <= StInit;
      idx_q   <= '0;
      last_q  <= IW'(TLR_PULSES);
      ir_q    <= 1'b0;
      tlr_q   <= 1'b0;
      len_q   <= '0;
      data_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ir_q    <= ir_d;
      tlr_q   <= tlr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rsp_q   <= rsp_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master against a behavioural TAP target (4-bit IR, IDCODE, USER).
module tb_jtag_master;

  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
  } tap_e;

  localparam logic [3:0]  IrIdcode  = 4'h1;
  localparam logic [3:0]  IrUser    = 4'h8;
  localparam logic [31:0] IdcodeVal = 32'h123450DF;
  localparam logic [31:0] UserIn    = 32'h12345678;

  logic        tck;
  logic        trst;
  logic        cmd_valid, cmd_ready, cmd_ir, cmd_tlr;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        jtag_tck, jtag_tms, jtag_tdi;
  logic        jtag_tdo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_master #(
    .MAX_LEN(32),
    .CLK_DIV(2)
  ) dut (
    .tck      (tck),
    .trst     (trst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ir   (cmd_ir),
    .cmd_tlr  (cmd_tlr),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
`ifdef JTAG_MASTER_RTI_EN
    .cmd_rti  (8'd0),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .jtag_tck (jtag_tck),
    .jtag_tms (jtag_tms),
    .jtag_tdi (jtag_tdi),
    .jtag_tdo (jtag_tdo)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // ---------------- TAP target model ----------------
  tap_e        tap_st   = TapTlr;
  logic [3:0]  tap_ir   = IrIdcode;
  logic [3:0]  ir_sr    = 4'h0;
  logic [31:0] dr_sr    = 32'h0;
  logic [31:0] user_out = 32'h0;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TapTlr:   return tms ? TapTlr   : TapRti;
      TapRti:   return tms ? TapSelDr : TapRti;
      TapSelDr: return tms ? TapSelIr : TapCapDr;
      TapCapDr: return tms ? TapEx1Dr : TapShDr;
      TapShDr:  return tms ? TapEx1Dr : TapShDr;
      TapEx1Dr: return tms ? TapUpdDr : TapPauDr;
      TapPauDr: return tms ? TapEx2Dr : TapPauDr;
      TapEx2Dr: return tms ? TapUpdDr : TapShDr;
      TapUpdDr: return tms ? TapSelDr : TapRti;
      TapSelIr: return tms ? TapTlr   : TapCapIr;
      TapCapIr: return tms ? TapEx1Ir : TapShIr;
      TapShIr:  return tms ? TapEx1Ir : TapShIr;
      TapEx1Ir: return tms ? TapUpdIr : TapPauIr;
      TapPauIr: return tms ? TapEx2Ir : TapPauIr;
      TapEx2Ir: return tms ? TapUpdIr : TapShIr;
      default:  return tms ? TapSelDr : TapRti;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    case (tap_st)
      TapTlr:   tap_ir <= IrIdcode;
      TapCapDr: dr_sr <= (tap_ir == IrIdcode) ? IdcodeVal : (tap_ir == IrUser) ? UserIn : 32'h0;
      TapShDr:  dr_sr <= {jtag_tdi, dr_sr[31:1]};
      TapUpdDr: if (tap_ir == IrUser) user_out <= dr_sr;
      TapCapIr: ir_sr <= 4'b0001;
      TapShIr:  ir_sr <= {jtag_tdi, ir_sr[3:1]};
      TapUpdIr: tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    jtag_tdo <= (tap_st == TapShDr) ? dr_sr[0] : (tap_st == TapShIr) ? ir_sr[0] : 1'b0;
  end

  // ---------------- pulse monitor (one cycle behind the pins) ----------------
  int   cyc   = 0;
  int   total = 0;
  logic tck_prev = 1'b0;
  logic tms_log  [1024];
  int   rise_cyc [1024];
  int   hi_len   [1024];

  always @(posedge tck) begin
    cyc      <= cyc + 1;
    tck_prev <= jtag_tck;
    if (jtag_tck && !tck_prev) begin
      tms_log[total]  <= jtag_tms;
      rise_cyc[total] <= cyc;
      total           <= total + 1;
    end
    if (!jtag_tck && tck_prev && total > 0) hi_len[total-1] <= cyc - rise_cyc[total-1];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!cmd_ready && k < 2000) begin
      @(negedge tck);
      k++;
    end
    chk(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_init(input int base, input string tag);
    logic [63:0] pat;
    logic        gap_ok, hi_ok;
    repeat (4) @(negedge tck);
    pat    = '0;
    gap_ok = 1'b1;
    hi_ok  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[62:0], tms_log[base+i]};
      if (hi_len[base+i] != 2) hi_ok = 1'b0;
      if (i > 0 && rise_cyc[base+i] - rise_cyc[base+i-1] != 4) gap_ok = 1'b0;
    end
    chk({tag, "_pulses"}, 32'(total - base), 32'd6);
    chk({tag, "_tms"}, pat[31:0], 32'h3E);
    chk({tag, "_period"}, 32'(gap_ok), 32'd1);
    chk({tag, "_high"}, 32'(hi_ok), 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic ir, input logic tlr, input logic [5:0] len,
                         input logic [31:0] data, input int exp_n, input logic [31:0] exp_rsp,
                         input int hold, output logic [63:0] pat);
    int   t0, base, k, b2;
    logic stable;
    wait_ready({tag, "_ready"});
    cmd_ir    = ir;
    cmd_tlr   = tlr;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    t0        = cyc;
    base      = total;
    @(posedge tck);
    #1 cmd_valid = 1'b0;
    @(negedge tck);
    chk({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
    k = 0;
    while (!rsp_valid && k < 3000) begin
      @(negedge tck);
      k++;
    end
    chk({tag, "_latency"}, 32'(cyc - t0), 32'(1 + exp_n * 4));
    chk({tag, "_pulses"}, 32'(total - base), 32'(exp_n));
    chk({tag, "_rsp"}, rsp_data, exp_rsp);
    pat = '0;
    for (int i = 0; i < exp_n && i < 64; i++) pat = {pat[62:0], tms_log[base+i]};
    if (hold > 0) begin
      cmd_ir    = 1'b0;
      cmd_tlr   = 1'b0;
      cmd_len   = 6'd8;
      cmd_data  = 32'hA5;
      cmd_valid = 1'b1;
      b2        = total;
      stable    = 1'b1;
      repeat (hold) begin
        @(negedge tck);
        if (!(rsp_valid === 1'b1 && rsp_data === exp_rsp && cmd_ready === 1'b0)) stable = 1'b0;
      end
      cmd_valid = 1'b0;
      chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
      chk({tag, "_hold_no_pulse"}, 32'(total - b2), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge tck);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] pat;
    logic        tck_hi;
    int          base;

    trst      = 1'b0;
    cmd_valid = 1'b0;
    cmd_ir    = 1'b0;
    cmd_tlr   = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge tck);
    chk("rst_tck", 32'(jtag_tck), 32'd0);
    chk("rst_tms", 32'(jtag_tms), 32'd1);
    chk("rst_tdi", 32'(jtag_tdi), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);

    trst = 1'b1;
    base = total;
    wait_ready("init_ready");
    tck_hi = 1'b0;
    repeat (10) begin
      @(negedge tck);
      if (jtag_tck !== 1'b0) tck_hi = 1'b1;
    end
    chk("idle_tck_low", 32'(tck_hi), 32'd0);
    check_init(base, "init");
    chk("init_tap_rti", 32'(tap_st), 32'(TapRti));

    run_cmd("idcode", 1'b0, 1'b0, 6'd32, 32'h0, 37, 32'h123450DF, 0, pat);
    run_cmd("ir_user", 1'b1, 1'b0, 6'd4, 32'h8, 10, 32'h1, 0, pat);
    chk("ir_user_tms", pat[31:0], 32'h306);
    run_cmd("user_dr", 1'b0, 1'b0, 6'd32, 32'hCAFEF00D, 37, 32'h12345678, 0, pat);
    chk("user_out", user_out, 32'hCAFEF00D);
    run_cmd("clamp", 1'b0, 1'b0, 6'd40, 32'h0, 37, 32'h12345678, 0, pat);
    chk("clamp_user_out", user_out, 32'h0);
    run_cmd("len0", 1'b0, 1'b0, 6'd0, 32'hFFFFFFFF, 5, 32'h0, 10, pat);
    chk("len0_tms", pat[31:0], 32'h16);
    run_cmd("tlr", 1'b0, 1'b1, 6'd7, 32'hFFFFFFFF, 6, 32'h0, 0, pat);
    chk("tlr_tms", pat[31:0], 32'h3E);
    chk("tlr_tap_ir", 32'(tap_ir), 32'(IrIdcode));

    // Interrupt an IR scan during the high phase of its first shift pulse.
    wait_ready("mid_ready");
    cmd_ir    = 1'b1;
    cmd_tlr   = 1'b0;
    cmd_len   = 6'd4;
    cmd_data  = 32'h8;
    cmd_valid = 1'b1;
    @(posedge tck);
    #1 cmd_valid = 1'b0;
    repeat (19) @(negedge tck);
    chk("mid_tck_high", 32'(jtag_tck), 32'd1);
    trst = 1'b0;
    #1;
    chk("mid_rst_tck", 32'(jtag_tck), 32'd0);
    chk("mid_rst_tms", 32'(jtag_tms), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge tck);
    trst = 1'b1;
    base = total;
    wait_ready("reinit_ready");
    check_init(base, "reinit");
    run_cmd("idcode2", 1'b0, 1'b0, 6'd32, 32'h0, 37, 32'h123450DF, 0, pat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
